// File: rtl/wishbone_spi_controller.sv
// wishbone_spi_controller
//   Wishbone slave that runs a mode-0 (CPOL=0, CPHA=0), 8-bit, MSB-first
//   SPI master. Software drives chip-select by hand through CTRL, sets the
//   SCK divider, starts a frame by writing DATA and polls STATUS.
//
//   Register map (word index on wb_adr_i):
//     0 DATA   W: [7:0] starts a transfer     R: {24'b0, rx_byte}
//     1 STATUS R: bit0 busy, bit1 rx_valid
//     2 CTRL   RW: bit0 cs_en, [15:8] div (SCK half-period = div+1 clk_i)
//     3 reads 0, writes ignored
//
//   Ports:
//     clk_i, rst_i            clock, asynchronous active-high reset
//     wb_cyc_i .. wb_dat_i    Wishbone slave request inputs
//     wb_dat_o, wb_ack_o      registered read data, single-cycle ack
//     spi_miso_i              serial data in
//     spi_mosi_o, spi_sck_o   serial data out, serial clock
//     spi_cs_o                chip select, active-low
module wishbone_spi_controller #(
   parameter logic [7:0] DEFAULT_DIV = 8'd3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [1:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   input  logic        spi_miso_i,
   output logic        spi_mosi_o,
   output logic        spi_sck_o,
   output logic        spi_cs_o
);

   typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_t;

   state_t      state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic [7:0]  tick_q, tick_d;
   logic [7:0]  half_q, half_d;
   logic [2:0]  bit_q, bit_d;
   logic        sck_d, mosi_d;
   logic        busy_q, busy_d;
   logic        rx_valid_q, rx_valid_d;

   // Register-interface state
   logic        cs_en_q;
   logic [7:0]  div_q;

   // Request captured at the request edge, acted on during the ack cycle
   logic        req_we_q;
   logic [1:0]  req_adr_q;
   logic [1:0]  req_sel_q;
   logic [15:0] req_dat_q;

   logic        req;
   logic [31:0] rd_mux;
   logic        data_wr, ctrl_wr, data_rd;

   logic        unused_bits;
   assign unused_bits = &{1'b0, wb_dat_i[31:16], wb_sel_i[3:2]};

   // Busy is an alias kept under its architectural name for observability
   logic busy;
   assign busy = busy_q;

   assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;

   always_comb begin
      rd_mux = 32'd0;
      case (wb_adr_i)
         2'd0:    rd_mux = {24'd0, rx_byte_q};
         2'd1:    rd_mux = {30'd0, rx_valid_q, busy_q};
         2'd2:    rd_mux = {16'd0, div_q, 7'd0, cs_en_q};
         default: rd_mux = 32'd0;
      endcase
   end

   assign data_wr = wb_ack_o & req_we_q & (req_adr_q == 2'd0) & req_sel_q[0];
   assign ctrl_wr = wb_ack_o & req_we_q & (req_adr_q == 2'd2);
   assign data_rd = wb_ack_o & ~req_we_q & (req_adr_q == 2'd0);

   // Bus handshake: ack one cycle after the request; read data registered
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_ack_o  <= 1'b0;
         wb_dat_o  <= 32'd0;
         req_we_q  <= 1'b0;
         req_adr_q <= 2'd0;
         req_sel_q <= 2'd0;
         req_dat_q <= 16'd0;
      end else begin
         wb_ack_o <= req;
         if (req) begin
            req_we_q  <= wb_we_i;
            req_adr_q <= wb_adr_i;
            req_sel_q <= wb_sel_i[1:0];
            req_dat_q <= wb_dat_i[15:0];
            wb_dat_o  <= wb_we_i ? 32'd0 : rd_mux;
         end else begin
            wb_dat_o  <= 32'd0;
         end
      end
   end

   // CTRL register; the CS pin follows cs_en without touching the shifter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cs_en_q  <= 1'b0;
         div_q    <= DEFAULT_DIV;
         spi_cs_o <= 1'b1;
      end else if (ctrl_wr) begin
         if (req_sel_q[0]) begin
            cs_en_q  <= req_dat_q[0];
            spi_cs_o <= ~req_dat_q[0];
         end
         if (req_sel_q[1]) div_q <= req_dat_q[15:8];
      end
   end

   // Shift engine. half_q snapshots div at each half-period start so a div
   // write during a transfer never disturbs a half-period already counting.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      rx_byte_d  = rx_byte_q;
      tick_d     = tick_q;
      half_d     = half_q;
      bit_d      = bit_q;
      sck_d      = spi_sck_o;
      mosi_d     = spi_mosi_o;
      busy_d     = busy_q;
      rx_valid_d = rx_valid_q;

      // A completing transfer below overrides this clear
      if (data_rd) rx_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (data_wr) begin
               shift_d    = req_dat_q[7:0];
               mosi_d     = req_dat_q[7];
               busy_d     = 1'b1;
               rx_valid_d = 1'b0;
               bit_d      = 3'd0;
               tick_d     = 8'd0;
               half_d     = div_q;
               state_d    = LEAD;
            end
         end
         LEAD: begin
            if (tick_q == half_q) begin
               tick_d  = 8'd0;
               half_d  = div_q;
               sck_d   = 1'b1;
               shift_d = {shift_q[6:0], spi_miso_i};
               state_d = TRAIL;
            end else begin
               tick_d = tick_q + 8'd1;
            end
         end
         TRAIL: begin
            if (tick_q == half_q) begin
               tick_d = 8'd0;
               half_d = div_q;
               sck_d  = 1'b0;
               if (bit_q == 3'd7) begin
                  rx_byte_d  = shift_q;
                  busy_d     = 1'b0;
                  rx_valid_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  // shift_q already moved at the rising edge; its MSB is next
                  bit_d   = bit_q + 3'd1;
                  mosi_d  = shift_q[7];
                  state_d = LEAD;
               end
            end else begin
               tick_d = tick_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         shift_q    <= 8'd0;
         rx_byte_q  <= 8'd0;
         tick_q     <= 8'd0;
         half_q     <= 8'd0;
         bit_q      <= 3'd0;
         spi_sck_o  <= 1'b0;
         spi_mosi_o <= 1'b0;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         rx_byte_q  <= rx_byte_d;
         tick_q     <= tick_d;
         half_q     <= half_d;
         bit_q      <= bit_d;
         spi_sck_o  <= sck_d;
         spi_mosi_o <= mosi_d;
         busy_q     <= busy_d;
         rx_valid_q <= rx_valid_d;
      end
   end

endmodule

// File: tb/tb_wishbone_spi_controller.sv
module tb_wishbone_spi_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [1:0]  wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        spi_miso_i, spi_mosi_o, spi_sck_o, spi_cs_o;

   always #5 clk = ~clk;

   wishbone_spi_controller #(.DEFAULT_DIV(8'd3)) dut (
      .clk_i(clk), .rst_i(rst),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .spi_miso_i(spi_miso_i), .spi_mosi_o(spi_mosi_o),
      .spi_sck_o(spi_sck_o), .spi_cs_o(spi_cs_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // SPI slave model: presents slave_byte MSB first, next bit after each SCK rise
   logic [7:0] slave_byte = 8'd0;
   int         slv_base   = 0;
   int         sck_rises  = 0;
   int         busy_cycles = 0;
   logic       mosi_q[$];
   longint     rise_t[$];

   function automatic logic slave_bit(input logic [7:0] b, input int k);
      logic [2:0] idx;
      if (k >= 8 || k < 0) return b[0];
      idx = 3'(7 - k);
      return b[idx];
   endfunction

   assign spi_miso_i = slave_bit(slave_byte, sck_rises - slv_base);

   always @(posedge spi_sck_o) begin
      mosi_q.push_back(spi_mosi_o);
      rise_t.push_back(longint'($time));
      sck_rises++;
   end

   always @(posedge clk) if (dut.busy === 1'b1) busy_cycles++;

   // One bus transaction; ack must arrive on the cycle after the request
   task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdat);
      int lat;
      bit got;
      got = 0; lat = -1; rdat = 32'd0;
      @(posedge clk); #1;
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (wb_ack_o) begin got = 1; lat = i; rdat = wb_dat_o; end
      end
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      check_eq("ack_latency", 32'(lat), 32'd0);
   endtask

   task automatic wb_read(input logic [1:0] adr, output logic [31:0] rdat);
      wb_xfer(1'b0, adr, 32'd0, 4'hF, rdat);
   endtask

   task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] dummy;
      wb_xfer(1'b1, adr, dat, sel, dummy);
   endtask

   // Full transfer against the reference: MOSI = tx MSB first, rx = slave byte,
   // busy = 16*(div+1) cycles, SCK period = 2*(div+1) cycles.
   task automatic do_transfer(input logic [7:0] tx, input logic [7:0] slv, input int dv,
                              input bit inject);
      int b0, r0, q0;
      bit done;
      logic [31:0] st, rd;
      logic [7:0] got;
      slave_byte = slv; slv_base = sck_rises;
      b0 = busy_cycles; r0 = sck_rises; q0 = mosi_q.size();
      wb_write(2'd0, {24'd0, tx}, 4'b0001);
      if (inject) begin
         repeat (3) @(posedge clk);
         wb_write(2'd0, 32'h55, 4'b0001);
      end
      done = 0; st = 32'd0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(posedge clk);
         wb_read(2'd1, st);
         if (st[0] == 1'b0) done = 1;
      end
      check_eq("xfer_done", 32'(done), 32'd1);
      check_eq("status_rxv", st, 32'h2);
      check_eq("sck_rises", 32'(sck_rises - r0), 32'd8);
      check_eq("busy_len", 32'(busy_cycles - b0), 32'(16 * (dv + 1)));
      if (sck_rises - r0 == 8) begin
         got = 8'd0;
         for (int i = 0; i < 8; i++) got = {got[6:0], mosi_q[q0 + i]};
         check_eq("mosi_stream", {24'd0, got}, {24'd0, tx});
         check_eq("sck_period", 32'(rise_t[q0 + 1] - rise_t[q0]), 32'(20 * (dv + 1)));
      end
      check_eq("mosi_hold", {31'd0, spi_mosi_o}, {31'd0, tx[0]});
      wb_read(2'd0, rd);
      check_eq("rx_byte", rd, {24'd0, slv});
      wb_read(2'd1, st);
      check_eq("status_clr", st, 32'h0);
   endtask

   initial begin
      logic [31:0] rd;
      int dv;
      bit hit;
      rst = 1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0; wb_adr_i = 0; wb_dat_i = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // Reset state
      check_eq("rst_cs", {31'd0, spi_cs_o}, 32'd1);
      check_eq("rst_sck", {31'd0, spi_sck_o}, 32'd0);
      check_eq("rst_mosi", {31'd0, spi_mosi_o}, 32'd0);
      check_eq("rst_ack", {31'd0, wb_ack_o}, 32'd0);
      check_eq("rst_dat", wb_dat_o, 32'd0);
      wb_read(2'd1, rd); check_eq("rst_status", rd, 32'h0);
      wb_read(2'd2, rd); check_eq("rst_ctrl", rd, 32'h0000_0300);
      wb_read(2'd0, rd); check_eq("rst_data", rd, 32'h0);

      // cs_en only; div keeps 3
      wb_write(2'd2, 32'h0000_0001, 4'b0001);
      @(posedge clk); #1;
      check_eq("cs_low", {31'd0, spi_cs_o}, 32'd0);
      do_transfer(8'hA5, 8'h3C, 3, 1'b0);

      // div = 0
      wb_write(2'd2, 32'h0000_0001, 4'b0011);
      do_transfer(8'hFF, 8'h96, 0, 1'b0);

      // Randomized divider / payloads
      for (int n = 0; n < 5; n++) begin
         dv = int'($urandom_range(0, 6));
         wb_write(2'd2, {16'd0, 8'(dv), 8'h01}, 4'b0011);
         wb_read(2'd2, rd);
         check_eq("ctrl_rb", rd, {16'd0, 8'(dv), 8'h01});
         do_transfer(8'($urandom), 8'($urandom), dv, 1'b0);
      end

      // DATA write while busy is ignored
      wb_write(2'd2, 32'h0000_0301, 4'b0011);
      do_transfer(8'hA5, 8'h3C, 3, 1'b1);

      // DATA write without lane 0 starts nothing
      dv = sck_rises;
      wb_write(2'd0, 32'h0000_0055, 4'b0010);
      repeat (20) @(posedge clk);
      check_eq("sel_no_sck", 32'(sck_rises - dv), 32'd0);
      wb_read(2'd1, rd); check_eq("sel_no_busy", rd, 32'h0);

      // Index 3 is inert
      wb_write(2'd3, 32'hFFFF_FFFF, 4'hF);
      wb_read(2'd3, rd); check_eq("adr3_rd", rd, 32'h0);
      wb_read(2'd2, rd); check_eq("adr3_ctrl", rd, 32'h0000_0301);

      // div = 255 boundary
      wb_write(2'd2, 32'h0000_FF01, 4'b0011);
      do_transfer(8'h3C, 8'hC3, 255, 1'b0);

      // Reset in the middle of a transfer
      wb_write(2'd2, 32'h0000_0301, 4'b0011);
      slave_byte = 8'h77; slv_base = sck_rises;
      dv = sck_rises;
      wb_write(2'd0, 32'h0000_005A, 4'b0001);
      hit = 0;
      for (int i = 0; i < 1000 && !hit; i++) begin
         @(posedge clk);
         if (sck_rises - dv >= 4) hit = 1;
      end
      check_eq("reach_bit4", 32'(hit), 32'd1);
      @(posedge clk); #3 rst = 1;
      #1;
      check_eq("mid_rst_sck", {31'd0, spi_sck_o}, 32'd0);
      check_eq("mid_rst_cs", {31'd0, spi_cs_o}, 32'd1);
      check_eq("mid_rst_busy", {31'd0, dut.busy}, 32'd0);
      check_eq("mid_rst_ack", {31'd0, wb_ack_o}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      wb_read(2'd2, rd); check_eq("post_rst_ctrl", rd, 32'h0000_0300);
      wb_read(2'd1, rd); check_eq("post_rst_status", rd, 32'h0);
      wb_write(2'd2, 32'h0000_0001, 4'b0001);
      do_transfer(8'h81, 8'($urandom), 3, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
